// File: rtl/sequenciador_movimentos.sv
// sequenciador_movimentos: move-list buffer and playback sequencer.
// Bytes from the serial receiver are stored in a synchronous RAM until the
// terminator arrives. On executar, the list is replayed one move at a time
// using the aciona / fim_movimento handshake.
// Optional single-step playback: define PASSO_A_PASSO_EN to add the passo
// input and the PAUSA state.
module sequenciador_movimentos #(
    parameter int         MOVE_W     = 3,
    parameter int         DEPTH      = 480,
    parameter int         ADDR_W     = 9,
    parameter logic [7:0] TERMINADOR = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              carregar,
    input  logic              executar,
    input  logic [7:0]        rx_dado,
    input  logic              rx_valido,
    input  logic              fim_movimento,
`ifdef PASSO_A_PASSO_EN
    input  logic              passo,
`endif
    output logic [MOVE_W-1:0] move,
    output logic              aciona,
    output logic              carga_pronta,
    output logic              execucao_pronta,
    output logic              estouro,
    output logic              erro_codigo,
    output logic [ADDR_W:0]   num_movimentos,
    output logic [ADDR_W:0]   indice,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        RECEBE    = 4'd1,
        ESCREVE   = 4'd2,
        CARREGADO = 4'd3,
        LE        = 4'd4,
        DADO      = 4'd5,
        ACIONA    = 4'd6,
        ESPERA    = 4'd7,
        PROXIMO   = 4'd8,
        FIM       = 4'd9
`ifdef PASSO_A_PASSO_EN
        ,
        PAUSA     = 4'd10
`endif
    } estado_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    estado_t           estado_q, estado_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W:0]   indice_q, indice_d;
    logic [ADDR_W:0]   prox_indice;
    logic [MOVE_W-1:0] move_q, move_d;
    logic [MOVE_W-1:0] dado_q, dado_d;
    logic              carga_q, carga_d;
    logic              exec_q, exec_d;
    logic              estouro_q, estouro_d;
    logic              erro_q, erro_d;

    logic              we;
    logic [ADDR_W-1:0] rd_addr;
    logic [MOVE_W-1:0] mem [DEPTH];
    logic [MOVE_W-1:0] ram_dado;
    logic              codigo_valido;

    assign prox_indice   = indice_q + (ADDR_W+1)'(1);
    assign codigo_valido = ((rx_dado >> MOVE_W) == 8'd0);

    // Move RAM: one write port fed during loading, registered read port.
    // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[num_q[ADDR_W-1:0]] <= dado_q;
        end
        ram_dado <= mem[rd_addr];
    end

    // Next-state and datapath decisions for loading and playback.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        estado_d  = estado_q;
        num_d     = num_q;
        indice_d  = indice_q;
        move_d    = move_q;
        dado_d    = dado_q;
        carga_d   = carga_q;
        exec_d    = exec_q;
        estouro_d = estouro_q;
        erro_d    = erro_q;
        we        = 1'b0;
        rd_addr   = indice_q[ADDR_W-1:0];

        case (estado_q)
            OCIOSO, CARREGADO, FIM: begin
                if (estado_q == FIM) begin
                    exec_d = 1'b1;
                end
                if (carregar) begin
                    estado_d  = RECEBE;
                    num_d     = '0;
                    estouro_d = 1'b0;
                    erro_d    = 1'b0;
                    carga_d   = 1'b0;
                    exec_d    = 1'b0;
                end else if (executar) begin
                    indice_d = '0;
                    exec_d   = 1'b0;
                    // An empty list skips playback; FIM raises execucao_pronta next edge.
                    estado_d = (num_q == '0) ? FIM : LE;
                end
            end
            RECEBE: begin
                if (rx_valido) begin
                    if (rx_dado == TERMINADOR) begin
                        estado_d = CARREGADO;
                        carga_d  = 1'b1;
                    end else if (codigo_valido) begin
                        dado_d   = rx_dado[MOVE_W-1:0];
                        estado_d = ESCREVE;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            ESCREVE: begin
                if (num_q < DEPTH_C) begin
                    we    = 1'b1;
                    num_d = num_q + (ADDR_W+1)'(1);
                end else begin
                    estouro_d = 1'b1;
                end
                estado_d = RECEBE;
            end
            LE: begin
                estado_d = DADO;
            end
            DADO: begin
                move_d   = ram_dado;
                estado_d = ACIONA;
            end
            ACIONA: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (fim_movimento) begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                if (prox_indice == num_q) begin
                    estado_d = FIM;
                    exec_d   = 1'b1;
                end else begin
                    indice_d = prox_indice;
`ifdef PASSO_A_PASSO_EN
                    estado_d = PAUSA;
`else
                    // PROXIMO also presents the next address, so the following
                    // aciona lands in the 3rd cycle after fim_movimento is sampled.
                    rd_addr  = prox_indice[ADDR_W-1:0];
                    estado_d = DADO;
`endif
                end
            end
`ifdef PASSO_A_PASSO_EN
            PAUSA: begin
                if (passo) begin
                    estado_d = LE;
                end
            end
`endif
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            estado_q  <= OCIOSO;
            num_q     <= '0;
            indice_q  <= '0;
            move_q    <= '0;
            dado_q    <= '0;
            carga_q   <= 1'b0;
            exec_q    <= 1'b0;
            estouro_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            num_q     <= num_d;
            indice_q  <= indice_d;
            move_q    <= move_d;
            dado_q    <= dado_d;
            carga_q   <= carga_d;
            exec_q    <= exec_d;
            estouro_q <= estouro_d;
            erro_q    <= erro_d;
        end
    end

    assign move            = move_q;
    assign aciona          = (estado_q == ACIONA);
    assign carga_pronta    = carga_q;
    assign execucao_pronta = exec_q;
    assign estouro         = estouro_q;
    assign erro_codigo     = erro_q;
    assign num_movimentos  = num_q;
    assign indice          = indice_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Testbench for sequenciador_movimentos: two instances (default depth and
// DEPTH=4) share all stimulus; a list-level reference model predicts the
// stored moves, flags, playback order and handshake latency.
module tb_sequenciador_movimentos;

    logic       clock = 1'b0;
    logic       reset;
    logic       carregar;
    logic       executar;
    logic [7:0] rx_dado;
    logic       rx_valido;
    logic       fim_movimento;
`ifdef PASSO_A_PASSO_EN
    logic       passo;
`endif

    logic [2:0] mv [2];
    logic       ac [2];
    logic       cp [2];
    logic       ep [2];
    logic       es [2];
    logic       er [2];
    logic [3:0] st [2];
    logic [9:0] nm [2];
    logic [9:0] ix [2];
    logic [9:0] nm0, ix0;
    logic [2:0] nm1, ix1;

    int n_checks = 0;
    int n_fail   = 0;

    // Current list as sent to the DUTs (terminator included).
    logic [7:0] lista [$];

    always #5 clock = ~clock;

    sequenciador_movimentos u_dut0 (
        .clock(clock), .reset(reset), .carregar(carregar), .executar(executar),
        .rx_dado(rx_dado), .rx_valido(rx_valido), .fim_movimento(fim_movimento),
`ifdef PASSO_A_PASSO_EN
        .passo(passo),
`endif
        .move(mv[0]), .aciona(ac[0]), .carga_pronta(cp[0]), .execucao_pronta(ep[0]),
        .estouro(es[0]), .erro_codigo(er[0]), .num_movimentos(nm0), .indice(ix0),
        .db_estado(st[0])
    );

    sequenciador_movimentos #(.DEPTH(4), .ADDR_W(2)) u_dut4 (
        .clock(clock), .reset(reset), .carregar(carregar), .executar(executar),
        .rx_dado(rx_dado), .rx_valido(rx_valido), .fim_movimento(fim_movimento),
`ifdef PASSO_A_PASSO_EN
        .passo(passo),
`endif
        .move(mv[1]), .aciona(ac[1]), .carga_pronta(cp[1]), .execucao_pronta(ep[1]),
        .estouro(es[1]), .erro_codigo(er[1]), .num_movimentos(nm1), .indice(ix1),
        .db_estado(st[1])
    );

    assign nm[0] = nm0;
    assign ix[0] = ix0;
    assign nm[1] = {7'd0, nm1};
    assign ix[1] = {7'd0, ix1};

    // ---------------- reference model (list level) ----------------
    function automatic int depth_of(input int k);
        return (k == 0) ? 480 : 4;
    endfunction

    function automatic int n_codes();
        int c = 0;
        foreach (lista[i]) begin
            if (lista[i] == 8'hFF) break;
            if (lista[i] < 8'd8) c++;
        end
        return c;
    endfunction

    function automatic int exp_n(input int k);
        int c = n_codes();
        return (c < depth_of(k)) ? c : depth_of(k);
    endfunction

    function automatic bit exp_ov(input int k);
        return n_codes() > depth_of(k);
    endfunction

    function automatic bit exp_er();
        foreach (lista[i]) begin
            if (lista[i] == 8'hFF) break;
            if (lista[i] >= 8'd8) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_move(input int j);
        int c = 0;
        foreach (lista[i]) begin
            if (lista[i] == 8'hFF) break;
            if (lista[i] < 8'd8) begin
                if (c == j) return lista[i][2:0];
                c++;
            end
        end
        return 3'd0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_bytes();
        foreach (lista[i]) begin
            rx_dado   = lista[i];
            rx_valido = 1'b1;
            @(negedge clock);
            rx_valido = 1'b0;
            repeat (2) @(negedge clock);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic load_list();
        carregar = 1'b1;
        @(negedge clock);
        carregar = 1'b0;
        send_bytes();
    endtask

    task automatic verify_load(input string name);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (nm[k] !== 10'(exp_n(k))) begin
                n_fail++;
                $display("FAIL %s num_movimentos[%0d]: got %0d, expected %0d", name, k, nm[k], exp_n(k));
            end
            n_checks++;
            if (es[k] !== exp_ov(k)) begin
                n_fail++;
                $display("FAIL %s estouro[%0d]: got %b, expected %b", name, k, es[k], exp_ov(k));
            end
            n_checks++;
            if (er[k] !== exp_er()) begin
                n_fail++;
                $display("FAIL %s erro_codigo[%0d]: got %b, expected %b", name, k, er[k], exp_er());
            end
            n_checks++;
            if (cp[k] !== 1'b1 || ep[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s carga/exec_pronta[%0d]: got %b/%b, expected 1/0", name, k, cp[k], ep[k]);
            end
        end
    endtask

    // Pulse executar and run one playback on instance k, answering each aciona
    // with fim_movimento fim_delay cycles later. Counts are in falling edges.
    task automatic play(input int k, input int fim_delay);
        int got      = 0;
        int fim_at   = -10;
        int trig     = 0;
        int last_fim = -10;
        int en       = exp_n(k);
        bit done     = 1'b0;
`ifdef PASSO_A_PASSO_EN
        int passo_at = -10;
`endif
        executar = 1'b1;
        for (int n = 1; n <= 600 && !done; n++) begin
            @(negedge clock);
            executar = 1'b0;
            if (n == fim_at + 1) fim_movimento = 1'b0;
`ifdef PASSO_A_PASSO_EN
            if (n == passo_at + 1) passo = 1'b0;
            if (n == passo_at) passo = 1'b1;
`endif
            if (ac[k] === 1'b1) begin
                n_checks++;
                if (got >= en) begin
                    n_fail++;
                    $display("FAIL play[%0d] extra aciona: pulse %0d, expected only %0d", k, got + 1, en);
                end else begin
                    if (mv[k] !== exp_move(got)) begin
                        n_fail++;
                        $display("FAIL play[%0d] move %0d: got %0d, expected %0d", k, got, mv[k], exp_move(got));
                    end
                    n_checks++;
                    if (n - trig != 3) begin
                        n_fail++;
                        $display("FAIL play[%0d] latency move %0d: got %0d cycles, expected 3", k, got, n - trig);
                    end
                end
                got++;
                fim_at = n + fim_delay;
            end
            if (n == fim_at) begin
                fim_movimento = 1'b1;
                last_fim      = n;
`ifdef PASSO_A_PASSO_EN
                if (got < en) begin
                    passo_at = n + 4;
                    trig     = passo_at;
                end
`else
                trig = n;
`endif
            end
            if (ep[k] === 1'b1) begin
                done = 1'b1;
                n_checks++;
                if (got != en) begin
                    n_fail++;
                    $display("FAIL play[%0d] aciona count: got %0d, expected %0d", k, got, en);
                end
                n_checks++;
                if (n != ((en == 0) ? 2 : last_fim + 2)) begin
                    n_fail++;
                    $display("FAIL play[%0d] execucao_pronta timing: got edge %0d, expected %0d", k, n,
                             (en == 0) ? 2 : last_fim + 2);
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL play[%0d] timeout: got %0d aciona, expected %0d and execucao_pronta", k, got, en);
        end
    endtask

    task automatic run_both(input int fim_delay);
        fork
            play(0, fim_delay);
            play(1, fim_delay);
        join
        fim_movimento = 1'b0;
`ifdef PASSO_A_PASSO_EN
        passo = 1'b0;
`endif
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({mv[k], ac[k], cp[k], ep[k], es[k], er[k], nm[k], ix[k], st[k]} !== '0) begin
                n_fail++;
                $display("FAIL %s outputs[%0d]: got move=%0d aciona=%b cp=%b ep=%b est=%b err=%b num=%0d ind=%0d st=%0d, expected all 0",
                         name, k, mv[k], ac[k], cp[k], ep[k], es[k], er[k], nm[k], ix[k], st[k]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("idle");
    endtask

    task automatic test_basic();
        lista = '{8'h02, 8'h05, 8'h01, 8'hFF};
        load_list();
        verify_load("basic");
        run_both(10);
    endtask

    task automatic test_empty();
        lista = '{8'hFF};
        load_list();
        verify_load("empty");
        run_both(10);
    endtask

    task automatic test_overflow();
        lista = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF};
        load_list();
        verify_load("overflow");
        run_both(4);
    endtask

    task automatic test_invalid();
        lista = '{8'h01, 8'h40, 8'h03, 8'hFF};
        load_list();
        verify_load("invalid");
        run_both(10);
    endtask

    task automatic test_replay();
        run_both(2);
    endtask

    task automatic test_carregar_priority();
        bit seen = 1'b0;
        lista = '{8'h04, 8'hFF};
        load_list();
        carregar = 1'b1;
        executar = 1'b1;
        @(negedge clock);
        carregar = 1'b0;
        executar = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cp[k] !== 1'b0 || nm[k] !== 10'd0) begin
                n_fail++;
                $display("FAIL priority clear[%0d]: got cp=%b num=%0d, expected 0/0", k, cp[k], nm[k]);
            end
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (ac[0] === 1'b1 || ac[1] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL priority aciona: got a pulse, expected none");
        end
        lista = '{8'h06, 8'h07, 8'hFF};
        send_bytes();
        verify_load("priority");
        run_both(3);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int len = $urandom_range(1, 6);
            lista.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) lista.push_back(8'($urandom_range(8, 254)));
                else lista.push_back(8'($urandom_range(0, 7)));
            end
            lista.push_back(8'hFF);
            load_list();
            verify_load("random");
            run_both($urandom_range(1, 12));
        end
    endtask

    task automatic test_reset_mid();
        int cnt     = 0;
        int fim_at  = -10;
        bit reached = 1'b0;
        lista = '{8'h01, 8'h02, 8'h03, 8'hFF};
        load_list();
        verify_load("reset_mid");
        executar = 1'b1;
        for (int n = 1; n <= 200 && !reached; n++) begin
            @(negedge clock);
            executar = 1'b0;
            if (n == fim_at + 1) fim_movimento = 1'b0;
            if (n == fim_at) fim_movimento = 1'b1;
`ifdef PASSO_A_PASSO_EN
            if (n == fim_at + 4) passo = 1'b1;
            if (n == fim_at + 5) passo = 1'b0;
`endif
            if (ac[0] === 1'b1) begin
                cnt++;
                if (cnt == 1) fim_at = n + 5;
                else reached = 1'b1;
            end
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL reset_mid second aciona: got %0d pulses, expected 2", cnt);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("reset_mid");
        reset = 1'b0;
        @(negedge clock);
        lista = '{8'hFF};
        run_both(10);
    endtask

    initial begin
        reset         = 1'b1;
        carregar      = 1'b0;
        executar      = 1'b0;
        rx_dado       = 8'h00;
        rx_valido     = 1'b0;
        fim_movimento = 1'b0;
`ifdef PASSO_A_PASSO_EN
        passo         = 1'b0;
`endif
        @(negedge clock);
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_invalid();
        test_replay();
        test_carregar_priority();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
